// File: rtl/imem_boot_pkg.sv
// Shared definitions for the boot loader, the imem and the core top.
// Holds the loader state encoding and the default memory/timeout sizing.
package imem_boot_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_DATA,
      ST_CSUM,
      ST_DONE,
      ST_ERR
   } boot_state_t;

   localparam int BYTES_PER_WORD      = 4;
   localparam int DEFAULT_DEPTH_WORDS = 1024;
   localparam int DEFAULT_TIMEOUT_CYC = 65535;

endpackage

// File: rtl/imem_boot_loader_asm.sv
// Little-endian byte-to-word assembler shared by the length, data and checksum fields.
// word/word_valid are presented in the same cycle as the 4th accepted byte.
module boot_word_assembler
   import imem_boot_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        byte_vld,
   input  logic [7:0]  byte_in,
   output logic        word_valid,
   output logic [31:0] word
);

   localparam int LANE_W = $clog2(BYTES_PER_WORD);
   localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(BYTES_PER_WORD - 1);

   logic [LANE_W-1:0] lane;
   logic [31:0]       shift_q;

   // Newest byte enters at the top, so the first byte ends up in bits 7:0.
   assign word       = {byte_in, shift_q[31:8]};
   assign word_valid = byte_vld && (lane == LANE_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lane <= '0;
      end else if (clear) begin
         lane <= '0;
      end else if (byte_vld) begin
         lane <= lane + LANE_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (byte_vld) begin
         shift_q <= word;
      end
   end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: fills imem from a framed byte stream (length, words, XOR checksum)
// while holding the core in reset; releases the core only on a verified load.
module imem_boot_loader
   import imem_boot_pkg::*;
#(
   parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
   parameter int ADDR_W      = 10,
   parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [7:0]        s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_waddr,
   output logic [31:0]       imem_wdata,
   output logic              core_rst_n,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   words_loaded
);

   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [31:0]      DEPTH_U  = 32'(DEPTH_WORDS);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
   localparam logic [ADDR_W:0]  WL_ONE   = (ADDR_W + 1)'(1);

   boot_state_t       state;
   logic              accept;
   logic              can_start;
   logic              asm_valid;
   logic [31:0]       asm_word;
   logic [TMO_W-1:0]  tmo_cnt;
   logic [ADDR_W:0]   len_q;
   logic [31:0]       xor_acc;
   logic              last_word;

   assign s_ready   = (state == ST_HDR) || (state == ST_DATA) || (state == ST_CSUM);
   assign accept    = s_valid && s_ready;
   assign can_start = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
   assign last_word = (words_loaded + WL_ONE) == len_q;

   boot_word_assembler u_asm (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (can_start),
      .byte_vld   (accept),
      .byte_in    (s_data),
      .word_valid (asm_valid),
      .word       (asm_word)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         imem_we      <= 1'b0;
         imem_waddr   <= '0;
         imem_wdata   <= '0;
         core_rst_n   <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         err          <= 1'b0;
         words_loaded <= '0;
         tmo_cnt      <= '0;
         xor_acc      <= '0;
         len_q        <= '0;
      end else begin
         imem_we <= 1'b0;
         case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
               if (start) begin
                  state        <= ST_HDR;
                  busy         <= 1'b1;
                  done         <= 1'b0;
                  err          <= 1'b0;
                  core_rst_n   <= 1'b0;
                  words_loaded <= '0;
                  xor_acc      <= '0;
                  tmo_cnt      <= '0;
               end
            end
            ST_HDR, ST_DATA, ST_CSUM: begin
               if (accept) begin
                  tmo_cnt <= '0;
                  if (asm_valid) begin
                     case (state)
                        ST_HDR: begin
                           if (asm_word > DEPTH_U) begin
                              state <= ST_ERR;
                              busy  <= 1'b0;
                              err   <= 1'b1;
                           end else if (asm_word == '0) begin
                              state <= ST_CSUM;
                           end else begin
                              len_q <= asm_word[ADDR_W:0];
                              state <= ST_DATA;
                           end
                        end
                        ST_DATA: begin
                           imem_we      <= 1'b1;
                           imem_waddr   <= words_loaded[ADDR_W-1:0];
                           imem_wdata   <= asm_word;
                           words_loaded <= words_loaded + WL_ONE;
                           xor_acc      <= xor_acc ^ asm_word;
                           if (last_word) begin
                              state <= ST_CSUM;
                           end
                        end
                        ST_CSUM: begin
                           busy <= 1'b0;
                           if (asm_word == xor_acc) begin
                              state      <= ST_DONE;
                              done       <= 1'b1;
                              core_rst_n <= 1'b1;
                           end else begin
                              state <= ST_ERR;
                              err   <= 1'b1;
                           end
                        end
                        default: ;
                     endcase
                  end
               end else if (tmo_cnt == TMO_LAST) begin
                  // Stalled link: abandon the load, any partial word is dropped.
                  state <= ST_ERR;
                  busy  <= 1'b0;
                  err   <= 1'b1;
               end else begin
                  tmo_cnt <= tmo_cnt + TMO_W'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader with a small imem and short timeout.
module tb_imem_boot_loader;

   localparam int DW  = 8;
   localparam int AW  = 3;
   localparam int TMO = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [7:0]    s_data = 8'h00;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic          imem_we;
   logic [AW-1:0] imem_waddr;
   logic [31:0]   imem_wdata;
   logic          core_rst_n;
   logic          busy;
   logic          done;
   logic          err;
   logic [AW:0]   words_loaded;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit ready_all;

   logic [31:0] wr_addr[$];
   logic [31:0] wr_data[$];
   int          wr_cyc[$];

   imem_boot_loader #(
      .DEPTH_WORDS (DW),
      .ADDR_W      (AW),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .s_data       (s_data),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .imem_we      (imem_we),
      .imem_waddr   (imem_waddr),
      .imem_wdata   (imem_wdata),
      .core_rst_n   (core_rst_n),
      .busy         (busy),
      .done         (done),
      .err          (err),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         wr_addr.push_back(32'(imem_waddr));
         wr_data.push_back(imem_wdata);
         wr_cyc.push_back(cyc);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish, got timeout want completion");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic clear_log();
      wr_addr.delete();
      wr_data.delete();
      wr_cyc.delete();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gap);
      int n;
      n = 0;
      s_data  = b;
      s_valid = 1'b1;
      ready_all = ready_all & s_ready;
      while (!s_ready && n < 20) begin
         tick();
         n++;
      end
      if (n == 20) begin
         total++;
         bad++;
         $error("FAIL ready_wait: got s_ready=0 for %0d cycles want 1", n);
      end
      tick();
      if (gap) begin
         s_valid = 1'b0;
         tick();
      end
   endtask

   task automatic send_word(input logic [31:0] w, input bit gap);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
   endtask

   initial begin
      // reset state
      tick();
      tick();
      check("rst_s_ready", 32'(s_ready), 0);
      check("rst_we", 32'(imem_we), 0);
      check("rst_waddr", 32'(imem_waddr), 0);
      check("rst_wdata", imem_wdata, 0);
      check("rst_core_rst_n", 32'(core_rst_n), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_err", 32'(err), 0);
      check("rst_words", 32'(words_loaded), 0);
      rst_n = 1'b1;
      tick();

      // 1: N=2 back-to-back
      clear_log();
      pulse_start();
      check("t1_busy", 32'(busy), 1);
      check("t1_ready", 32'(s_ready), 1);
      send_word(32'd2, 1'b0);
      send_word(32'h0000_0013, 1'b0);
      check("t1_we0", 32'(imem_we), 1);
      check("t1_waddr0", 32'(imem_waddr), 0);
      check("t1_wdata0", imem_wdata, 32'h0000_0013);
      check("t1_core_held", 32'(core_rst_n), 0);
      send_word(32'h00A0_0093, 1'b0);
      check("t1_waddr1", 32'(imem_waddr), 1);
      check("t1_wdata1", imem_wdata, 32'h00A0_0093);
      send_word(32'h00A0_0080, 1'b0);
      s_valid = 1'b0;
      check("t1_done", 32'(done), 1);
      check("t1_core_rst_n", 32'(core_rst_n), 1);
      check("t1_busy_end", 32'(busy), 0);
      check("t1_words", 32'(words_loaded), 2);
      check("t1_nwr", wr_addr.size(), 2);
      if (wr_addr.size() == 2) begin
         check("t1_log_addr1", wr_addr[1], 1);
         check("t1_spacing", wr_cyc[1] - wr_cyc[0], 4);
      end

      // 2: same stream with a gap after every byte
      clear_log();
      pulse_start();
      check("t2_core_drop", 32'(core_rst_n), 0);
      check("t2_done_clr", 32'(done), 0);
      check("t2_words_clr", 32'(words_loaded), 0);
      ready_all = 1'b1;
      send_word(32'd2, 1'b1);
      send_word(32'h0000_0013, 1'b1);
      send_word(32'h00A0_0093, 1'b1);
      send_word(32'h00A0_0080, 1'b1);
      check("t2_ready_all", 32'(ready_all), 1);
      check("t2_done", 32'(done), 1);
      check("t2_core_rst_n", 32'(core_rst_n), 1);
      check("t2_words", 32'(words_loaded), 2);
      check("t2_nwr", wr_addr.size(), 2);
      if (wr_addr.size() == 2) begin
         check("t2_addr0", wr_addr[0], 0);
         check("t2_data0", wr_data[0], 32'h0000_0013);
         check("t2_data1", wr_data[1], 32'h00A0_0093);
         check("t2_spacing", wr_cyc[1] - wr_cyc[0], 8);
      end

      // 3: bad checksum, then a good reload
      clear_log();
      pulse_start();
      send_word(32'd1, 1'b0);
      send_word(32'hDEAD_BEEF, 1'b0);
      send_word(32'h0000_0000, 1'b0);
      s_valid = 1'b0;
      check("t3_err", 32'(err), 1);
      check("t3_done", 32'(done), 0);
      check("t3_core_rst_n", 32'(core_rst_n), 0);
      check("t3_nwr", wr_addr.size(), 1);
      if (wr_addr.size() == 1) check("t3_data", wr_data[0], 32'hDEAD_BEEF);
      pulse_start();
      check("t3_err_clr", 32'(err), 0);
      send_word(32'd1, 1'b0);
      send_word(32'hDEAD_BEEF, 1'b0);
      send_word(32'hDEAD_BEEF, 1'b0);
      s_valid = 1'b0;
      check("t3_done2", 32'(done), 1);
      check("t3_words2", 32'(words_loaded), 1);

      // 4: oversize header, empty load, full-depth load
      clear_log();
      pulse_start();
      send_word(32'd9, 1'b0);
      s_valid = 1'b0;
      check("t4_big_err", 32'(err), 1);
      check("t4_big_ready", 32'(s_ready), 0);
      check("t4_big_nwr", wr_addr.size(), 0);
      pulse_start();
      send_word(32'd0, 1'b0);
      send_word(32'd0, 1'b0);
      s_valid = 1'b0;
      check("t4_zero_done", 32'(done), 1);
      check("t4_zero_words", 32'(words_loaded), 0);
      check("t4_zero_nwr", wr_addr.size(), 0);
      pulse_start();
      send_word(32'd8, 1'b0);
      for (int i = 1; i <= 8; i++) send_word(32'(i), 1'b0);
      send_word(32'h0000_0008, 1'b0);
      s_valid = 1'b0;
      check("t4_full_done", 32'(done), 1);
      check("t4_full_words", 32'(words_loaded), 8);
      check("t4_full_nwr", wr_addr.size(), 8);
      if (wr_addr.size() == 8) begin
         check("t4_full_addr7", wr_addr[7], 7);
         check("t4_full_data7", wr_data[7], 32'd8);
      end

      // 5: stall after 6 bytes
      clear_log();
      pulse_start();
      send_word(32'd1, 1'b0);
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      s_valid = 1'b0;
      for (int i = 0; i < TMO - 1; i++) tick();
      check("t5_err_early", 32'(err), 0);
      check("t5_busy_early", 32'(busy), 1);
      tick();
      check("t5_err", 32'(err), 1);
      check("t5_busy", 32'(busy), 0);
      check("t5_nwr", wr_addr.size(), 0);

      // 6: reset on the 4th data byte, then start ignored while busy
      clear_log();
      pulse_start();
      send_word(32'd1, 1'b0);
      send_byte(8'hEF, 1'b0);
      send_byte(8'hBE, 1'b0);
      send_byte(8'hAD, 1'b0);
      s_data = 8'hDE;
      rst_n  = 1'b0;
      tick();
      check("t6_we", 32'(imem_we), 0);
      check("t6_ready", 32'(s_ready), 0);
      check("t6_waddr", 32'(imem_waddr), 0);
      check("t6_wdata", imem_wdata, 0);
      check("t6_busy", 32'(busy), 0);
      check("t6_words", 32'(words_loaded), 0);
      check("t6_err", 32'(err), 0);
      rst_n   = 1'b1;
      s_valid = 1'b0;
      tick();
      check("t6_nwr", wr_addr.size(), 0);
      pulse_start();
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b0);
      s_valid = 1'b0;
      pulse_start();
      check("t6_busy_start", 32'(busy), 1);
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b0);
      send_word(32'd0, 1'b0);
      s_valid = 1'b0;
      check("t6_done", 32'(done), 1);
      check("t6_nwr2", wr_addr.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
Boot-time controller that fills the instruction memory from a byte-serial stream (UART/debug bridge) while holding the RISC-V core in reset.
- Assembles little-endian bytes into 32-bit words and issues one write per word at consecutive word addresses.
- Verifies a trailing XOR checksum, then releases the core.
- Sits between the host link and the imem write port; the fetch side of imem is untouched.

Parameters:
DEPTH_WORDS, 1024, imem capacity in 32-bit words
ADDR_W, 10, word-address width; must satisfy 2**ADDR_W >= DEPTH_WORDS
TIMEOUT_CYC, 65535, max idle cycles between accepted bytes before the load aborts

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
start  in  1  pulse: begin a load; honoured only in IDLE, DONE or ERR
s_data  in  8  stream byte
s_valid  in  1  stream byte valid
s_ready  out  1  loader accepts byte; transfer when s_valid & s_ready at clk edge
imem_we  out  1  one-cycle word write strobe
imem_waddr  out  ADDR_W  word address; the core fetch side uses byte address = imem_waddr*4
imem_wdata  out  32  assembled word
core_rst_n  out  1  active-low reset to the core; 1 only in DONE
busy  out  1  high in HDR, DATA, CSUM
done  out  1  high in DONE
err  out  1  high in ERR
words_loaded  out  ADDR_W+1  count of words written in the current or last load

Behaviour:
- Reset values: s_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, core_rst_n=0, busy=0, done=0, err=0, words_loaded=0; state=IDLE.
- imem contents are never cleared by this block.
- Stream framing: 4-byte length N (LE), then N data words (LE, 4N bytes), then a 4-byte checksum (LE).
- Valid checksum = XOR of all N data words; for N=0 it is 0.
- All outputs are registered except s_ready, which is decoded from the state register: 1 in HDR, DATA, CSUM.

State transitions:
- IDLE: on start -> HDR; clear byte lane, words_loaded, XOR accumulator and timeout counter.
- HDR: after 4th byte:
  - N > DEPTH_WORDS -> ERR.
  - N == 0 -> CSUM.
  - Otherwise -> DATA.
  - N == DEPTH_WORDS is legal.
- DATA: byte lane counter 0..3.
  - On 4th byte accepted at edge t: imem_we=1 for exactly the cycle after t, with imem_waddr=words_loaded (pre-increment) and the assembled word.
  - words_loaded increments at that same edge; the accumulator XORs in the word.
  - After word N-1 is accepted -> CSUM.
  - Back-to-back bytes sustain one word every 4 cycles.
- CSUM: after 4th byte: match -> DONE, mismatch -> ERR.
- DONE: core_rst_n=1, done=1.
- ERR: err=1, core_rst_n=0. Words already written stay in imem.

Start, timeout and reset:
- start from DONE or ERR -> HDR: core_rst_n drops to 0 on the same edge, done/err clear, words_loaded resets.
- start while busy: ignored.
- Timeout counter resets on every accepted byte and counts in HDR/DATA/CSUM. Reaching TIMEOUT_CYC -> ERR.
- A partial word is discarded; no write is issued.
- s_valid while s_ready=0: byte not consumed.
- rst_n low mid-load: next edge returns all outputs to reset values and state to IDLE; any pending imem_we is cancelled.

Decomposition:
- Shared package imem_boot_pkg:
  - state enum (IDLE, HDR, DATA, CSUM, DONE, ERR)
  - BYTES_PER_WORD=4
  - default DEPTH_WORDS/TIMEOUT_CYC constants, shared with the imem and core top.
- One natural sub-module: boot_word_assembler. It contains the byte lane counter, the LE shift register and the word_valid pulse, and is reused for the length, data and checksum fields.
- FSM, timeout counter, address counter and XOR accumulator stay in the top module.

Test Plan:
1. Stream N=2, words 0x00000013, 0x00A00093, checksum 0x00A00080, no gaps -> imem_we pulses at waddr 0 then 1 with those values, four cycles apart; DONE; core_rst_n=1; words_loaded=2.
2. Same stream with s_valid toggling 1/0 every cycle -> identical writes and final state; s_ready stays 1 throughout the transfer.
3. N=1, word 0xDEADBEEF, checksum 0x00000000 -> the write occurs, then ERR; err=1, core_rst_n=0. Then start plus a correct stream -> DONE.
4. Header N=DEPTH_WORDS+1 -> ERR right after the 4th header byte, with zero imem_we pulses. Header N=0 with checksum 0 -> DONE, words_loaded=0.
5. TIMEOUT_CYC=16: send 6 bytes of a valid N=1 stream, then stall 16 cycles -> ERR; no write issued for the partial word.
6. rst_n low for one cycle on the same edge as the 4th data byte -> no imem_we, all outputs at reset values. start pulsed in HDR -> no effect.
